// File: rtl/riscv_pu_ex_forward_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_pu_ex_forward_ctrl
//
// Operand-forwarding and load-use hazard controller for the EX-stage ALU.
// Tracks the destination register of the instructions in EX, MEM and WB and
// produces registered operand selects that line up with the instruction
// entering EX. A load in EX whose rd is read by the instruction in ID causes
// a one-cycle combinational stall and a bubble into EX.
//
// Select encoding (all three muxes):
//   0 : register file value
//   1 : alu_data  (result of the instruction now moving to MEM)
//   2 : wr_data   (write-back data of the instruction now moving to WB,
//                  this also covers load data)
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), async active-low reset
//   i_hold                 global freeze; no state changes while high
//   i_flush                kill the instruction currently in ID
//   i_id_*                 decoded fields of the instruction in ID
//   o_mux1_src/2/3         registered operand-1 / operand-2 / store-data select
//   o_stall                load-use stall request (combinational)
//   o_ex_valid             EX slot holds a valid instruction
//   o_stall_cnt, o_fwd_cnt performance counters (only with RISCV_FWD_PERF_EN)
//
// Build option:
//   RISCV_FWD_PERF_EN  adds the stall and forward performance counters.
//
// Handshake: this block has no valid/ready pair. o_stall is a request that the
// PC/IF/ID stages hold their content for one cycle; EX receives a bubble in
// the same cycle. i_hold freezes every register here, including counters.
// ---------------------------------------------------------------------------
module riscv_pu_ex_forward_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_hold,
  input  logic                      i_flush,
  input  logic                      i_id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2_addr,
  input  logic                      i_id_rs1_used,
  input  logic                      i_id_rs2_alu_used,
  input  logic                      i_id_rs2_store_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
  input  logic                      i_id_reg_write,
  input  logic                      i_id_read,
  output logic [1:0]                o_mux1_src,
  output logic [1:0]                o_mux2_src,
  output logic [1:0]                o_mux3_src,
  output logic                      o_stall,
  output logic                      o_ex_valid
`ifdef RISCV_FWD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]      o_stall_cnt,
  output logic [CNT_WIDTH-1:0]      o_fwd_cnt
`endif
);

  localparam logic [1:0] SRC_RF  = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_WR  = 2'd2;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      read;
  } slot_t;

  slot_t      ex_q, ex_d;
  slot_t      mem_q;
  slot_t      wb_q;
  logic [1:0] mux1_q, mux1_d;
  logic [1:0] mux2_q, mux2_d;
  logic [1:0] mux3_q, mux3_d;

  logic ex_prod, mem_prod;
  logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
  logic load_use;
  logic capture;

  // Forward source for one operand. A load in EX can never feed alu_data; a
  // match against it only happens under a stall, so it is skipped here and
  // the operand falls through to the MEM check.
  function automatic logic [1:0] pick_src(input logic used,
                                          input logic ex_hit,
                                          input logic mem_hit,
                                          input logic ex_is_load);
    logic [1:0] src;
    src = SRC_RF;
    if (used) begin
      if (ex_hit && !ex_is_load) src = SRC_ALU;
      else if (mem_hit)          src = SRC_WR;
    end
    return src;
  endfunction

  // x0 is never a producer, so it can never be forwarded from.
  assign ex_prod  = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != '0);
  assign mem_prod = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);

  assign rs1_ex_hit  = ex_prod  & (i_id_rs1_addr == ex_q.rd);
  assign rs2_ex_hit  = ex_prod  & (i_id_rs2_addr == ex_q.rd);
  assign rs1_mem_hit = mem_prod & (i_id_rs1_addr == mem_q.rd);
  assign rs2_mem_hit = mem_prod & (i_id_rs2_addr == mem_q.rd);

  assign load_use = ex_q.read &
                    ((i_id_rs1_used & rs1_ex_hit) |
                     ((i_id_rs2_alu_used | i_id_rs2_store_used) & rs2_ex_hit));

  // Flush beats stall: the killed instruction must not hold up the front end.
  // Deliberately not gated by i_hold so the request stays visible while frozen.
  assign o_stall = i_id_valid & ~i_flush & load_use;
  assign capture = i_id_valid & ~i_flush & ~o_stall;

  always_comb begin
    ex_d   = '0;
    mux1_d = SRC_RF;
    mux2_d = SRC_RF;
    mux3_d = SRC_RF;
    if (capture) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = i_id_rd_addr;
      ex_d.reg_write = i_id_reg_write;
      ex_d.read      = i_id_read;
      mux1_d = pick_src(i_id_rs1_used,       rs1_ex_hit, rs1_mem_hit, ex_q.read);
      mux2_d = pick_src(i_id_rs2_alu_used,   rs2_ex_hit, rs2_mem_hit, ex_q.read);
      mux3_d = pick_src(i_id_rs2_store_used, rs2_ex_hit, rs2_mem_hit, ex_q.read);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      mux1_q <= SRC_RF;
      mux2_q <= SRC_RF;
      mux3_q <= SRC_RF;
    end else if (!i_hold) begin
      wb_q   <= mem_q;
      mem_q  <= ex_q;
      ex_q   <= ex_d;
      mux1_q <= mux1_d;
      mux2_q <= mux2_d;
      mux3_q <= mux3_d;
    end
  end

  assign o_mux1_src = mux1_q;
  assign o_mux2_src = mux2_q;
  assign o_mux3_src = mux3_q;
  assign o_ex_valid = ex_q.valid;

  // The WB slot is tracked for visibility only: the register file writes
  // through at WB, so nothing is ever forwarded from it. The MEM load flag is
  // likewise irrelevant because wr_data already carries load data.
  logic slot_unused;
  assign slot_unused = ^{wb_q, mem_q.read};

`ifdef RISCV_FWD_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (o_stall) stall_cnt_d = stall_cnt_q + 1'b1;
    if (capture && ((mux1_d | mux2_d | mux3_d) != 2'd0)) fwd_cnt_d = fwd_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!i_hold) begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_fwd_cnt   = fwd_cnt_q;
`else
  logic [CNT_WIDTH-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_riscv_pu_ex_forward_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_pu_ex_forward_ctrl
//
// Directed hazard sequences plus a random ALU-only stream. Each driven ID
// instruction pushes the expected EX content {valid, mux1, mux2, mux3} onto
// exp_q; it is popped and compared one cycle later. o_stall is checked
// combinationally in the cycle it is driven.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_riscv_pu_ex_forward_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          hold, flush, id_valid;
  logic [AW-1:0] rs1, rs2, rd;
  logic          rs1_used, rs2_alu_used, rs2_store_used, reg_write, id_read;
  logic [1:0]    mux1, mux2, mux3;
  logic          stall, ex_valid;
`ifdef RISCV_FWD_PERF_EN
  logic [CW-1:0] stall_cnt, fwd_cnt;
`endif

  riscv_pu_ex_forward_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_hold              (hold),
    .i_flush             (flush),
    .i_id_valid          (id_valid),
    .i_id_rs1_addr       (rs1),
    .i_id_rs2_addr       (rs2),
    .i_id_rs1_used       (rs1_used),
    .i_id_rs2_alu_used   (rs2_alu_used),
    .i_id_rs2_store_used (rs2_store_used),
    .i_id_rd_addr        (rd),
    .i_id_reg_write      (reg_write),
    .i_id_read           (id_read),
    .o_mux1_src          (mux1),
    .o_mux2_src          (mux2),
    .o_mux3_src          (mux3),
    .o_stall             (stall),
    .o_ex_valid          (ex_valid)
`ifdef RISCV_FWD_PERF_EN
    ,
    .o_stall_cnt         (stall_cnt),
    .o_fwd_cnt           (fwd_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int stall_exp = 0;
  int fwd_exp   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1u;
    logic          rs2au;
    logic          rs2su;
    logic [AW-1:0] rd;
    logic          rw;
    logic          ld;
  } id_t;

  function automatic id_t f_alu(input logic [AW-1:0] d, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    return '{1'b1, s1, s2, 1'b1, 1'b1, 1'b0, d, 1'b1, 1'b0};
  endfunction
  // addi: rs2 field carries an arbitrary value that must be ignored
  function automatic id_t f_addi(input logic [AW-1:0] d, input logic [AW-1:0] s1, input logic [AW-1:0] s2f);
    return '{1'b1, s1, s2f, 1'b1, 1'b0, 1'b0, d, 1'b1, 1'b0};
  endfunction
  function automatic id_t f_ld(input logic [AW-1:0] d, input logic [AW-1:0] s1);
    return '{1'b1, s1, 5'd0, 1'b1, 1'b0, 1'b0, d, 1'b1, 1'b1};
  endfunction
  function automatic id_t f_sd(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    return '{1'b1, s1, s2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
  endfunction
  function automatic id_t f_nop();
    return '0;
  endfunction

  function automatic logic [6:0] ex_e(input logic v, input logic [1:0] m1,
                                      input logic [1:0] m2, input logic [1:0] m3);
    return {v, m1, m2, m3};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input id_t ins, input logic fl, input logic hd,
                      input logic exp_stall, input logic [6:0] exp_ex);
    logic [6:0] e;
    @(negedge clk);
    id_valid       = ins.valid;
    rs1            = ins.rs1;
    rs2            = ins.rs2;
    rs1_used       = ins.rs1u;
    rs2_alu_used   = ins.rs2au;
    rs2_store_used = ins.rs2su;
    rd             = ins.rd;
    reg_write      = ins.rw;
    id_read        = ins.ld;
    flush          = fl;
    hold           = hd;
    #1;
    check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
    exp_q.push_back(exp_ex);
    if (!hd) begin
      if (exp_stall) stall_exp++;
      if (exp_ex[5:0] != 6'd0) fwd_exp++;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("ex_valid", {31'd0, ex_valid}, {31'd0, e[6]});
    check_val("mux1", {30'd0, mux1}, {30'd0, e[5:4]});
    check_val("mux2", {30'd0, mux2}, {30'd0, e[3:2]});
    check_val("mux3", {30'd0, mux3}, {30'd0, e[1:0]});
  endtask

  task automatic drain();
    repeat (3) step(f_nop(), 1'b0, 1'b0, 1'b0, 7'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check_val({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    check_val({tag, "_mux"}, {26'd0, mux1, mux2, mux3}, 32'd0);
`ifdef RISCV_FWD_PERF_EN
    check_val({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    check_val({tag, "_fwd_cnt"}, fwd_cnt, 32'd0);
`endif
  endtask

  // random-stream model: destinations captured 1 and 2 cycles earlier
  logic          h1v, h2v;
  logic [AW-1:0] h1rd, h2rd;

  function automatic logic [1:0] dist_src(input logic used, input logic [AW-1:0] r);
    if (!used) return 2'd0;
    if (h1v && h1rd == r) return 2'd1;
    if (h2v && h2rd == r) return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    id_t  ins;
    logic cap, fl;

    hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    rs1_used = 1'b0; rs2_alu_used = 1'b0; rs2_store_used = 1'b0;
    reg_write = 1'b0; id_read = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // back-to-back ALU -> alu_data forward
    drain();
    step(f_alu(5, 1, 2), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_alu(6, 5, 7), 1'b0, 1'b0, 1'b0, ex_e(1, 1, 0, 0));
    // distance two -> wr_data forward on operand 2
    step(f_alu(5, 1, 2), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_nop(),        1'b0, 1'b0, 1'b0, ex_e(0, 0, 0, 0));
    step(f_alu(6, 7, 5), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 2, 0));

    // load-use: one stall cycle, bubble, then wr_data on both operands
    drain();
    step(f_ld(5, 1),     1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_alu(6, 5, 5), 1'b0, 1'b0, 1'b1, ex_e(0, 0, 0, 0));
    step(f_alu(6, 5, 5), 1'b0, 1'b0, 1'b0, ex_e(1, 2, 2, 0));

    // x0 never forwards; unused rs2 ignored
    drain();
    step(f_addi(0, 0, 0), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_alu(1, 0, 0),  1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_addi(3, 1, 0), 1'b0, 1'b0, 1'b0, ex_e(1, 1, 0, 0));
    step(f_addi(3, 3, 3), 1'b0, 1'b0, 1'b0, ex_e(1, 1, 0, 0));

    // store data forward, then flushed store and flushed load-use
    drain();
    step(f_alu(5, 1, 2), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_sd(2, 5),     1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 1));
    step(f_alu(5, 1, 2), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_sd(2, 5),     1'b1, 1'b0, 1'b0, ex_e(0, 0, 0, 0));
    step(f_ld(5, 1),     1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    step(f_alu(6, 5, 5), 1'b1, 1'b0, 1'b0, ex_e(0, 0, 0, 0));

    // hold during load-use: EX stays on the load, stall stays asserted
    drain();
    step(f_ld(5, 1), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    repeat (3) step(f_alu(6, 5, 5), 1'b0, 1'b1, 1'b1, ex_e(1, 0, 0, 0));
    step(f_alu(6, 5, 5), 1'b0, 1'b0, 1'b1, ex_e(0, 0, 0, 0));
`ifdef RISCV_FWD_PERF_EN
    check_val("stall_cnt", stall_cnt, stall_exp);
`endif
    step(f_alu(6, 5, 5), 1'b0, 1'b0, 1'b0, ex_e(1, 2, 2, 0));
`ifdef RISCV_FWD_PERF_EN
    check_val("fwd_cnt", fwd_cnt, fwd_exp);
`endif

    // asynchronous reset in the middle of a stall
    drain();
    step(f_ld(5, 1), 1'b0, 1'b0, 1'b0, ex_e(1, 0, 0, 0));
    @(negedge clk);
    ins = f_alu(6, 5, 5);
    id_valid = ins.valid; rs1 = ins.rs1; rs2 = ins.rs2;
    rs1_used = ins.rs1u; rs2_alu_used = ins.rs2au; rs2_store_used = ins.rs2su;
    rd = ins.rd; reg_write = ins.rw; id_read = ins.ld;
    #1 check_val("pre_reset_stall", {31'd0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    stall_exp = 0;
    fwd_exp   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(f_nop(), 1'b0, 1'b0, 1'b0, ex_e(0, 0, 0, 0));

    // random ALU stream against a distance-based model
    h1v = 1'b0; h2v = 1'b0; h1rd = '0; h2rd = '0;
    for (int i = 0; i < 60; i++) begin
      ins.valid = ($urandom_range(0, 9) != 0);
      ins.rs1   = AW'($urandom_range(0, 3));
      ins.rs2   = AW'($urandom_range(0, 3));
      ins.rd    = AW'($urandom_range(0, 3));
      ins.rs1u  = 1'($urandom_range(0, 1));
      ins.rs2au = 1'($urandom_range(0, 1));
      ins.rs2su = 1'($urandom_range(0, 1));
      ins.rw    = ($urandom_range(0, 3) != 0);
      ins.ld    = 1'b0;
      fl        = ($urandom_range(0, 9) == 0);
      cap       = ins.valid & ~fl;
      step(ins, fl, 1'b0, 1'b0,
           cap ? ex_e(1'b1, dist_src(ins.rs1u, ins.rs1), dist_src(ins.rs2au, ins.rs2),
                      dist_src(ins.rs2su, ins.rs2))
               : 7'd0);
      h2v  = h1v;
      h2rd = h1rd;
      h1v  = cap & ins.rw & (ins.rd != '0);
      h1rd = ins.rd;
    end
`ifdef RISCV_FWD_PERF_EN
    check_val("fwd_cnt_final", fwd_cnt, fwd_exp);
    check_val("stall_cnt_final", stall_cnt, stall_exp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
